// File: rtl/usb_ls_bus_arbiter.sv
// Shared low-speed D+/D- pair between a HID host port and a simulated device,
// with turnaround-enforcing ownership FSM. USB_BUS_SE0_DETECT_EN adds SE0 bus-reset detect.
module usb_ls_bus_arbiter #(
    parameter int PROP_DELAY   = 1,
    parameter int TA_CYCLES    = 2,
    parameter int RESET_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       host_dp_o,
    input  logic       host_dm_o,
    input  logic       host_oe,
    input  logic       dev_dp_o,
    input  logic       dev_dm_o,
    input  logic       dev_oe,
    input  logic       clr_cnt,
    output logic       host_dp_i,
    output logic       host_dm_i,
    output logic       dev_dp_i,
    output logic       dev_dm_i,
    output logic [1:0] owner,
    output logic       conflict,
    output logic [7:0] conflict_cnt,
    output logic       bus_reset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_DEV,
        S_TURN,
        S_CONFLICT
    } state_t;

    // Line word is {host_dp, host_dm, dev_dp, dev_dm}; J on both sides.
    localparam logic [3:0] LINE_J  = 4'b0101;
    localparam logic [7:0] TA_LOAD = 8'(TA_CYCLES - 1);

    state_t                         r_state, w_next;
    logic   [7:0]                   r_ta_cnt;
    logic   [1:0]                   r_owner, w_owner;
    logic                           r_conflict;
    logic   [7:0]                   r_cnt;
    logic                           w_entry;
    logic   [3:0]                   w_line;
    logic   [PROP_DELAY-1:0][3:0]   r_pipe;

    function automatic state_t f_grant(input logic h, input logic d);
        if (h && d)  return S_CONFLICT;
        else if (h)  return S_HOST;
        else if (d)  return S_DEV;
        else         return S_IDLE;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = f_grant(host_oe, dev_oe);
            S_HOST:     if (!host_oe) w_next = S_TURN;
                        else if (dev_oe) w_next = S_CONFLICT;
            S_DEV:      if (!dev_oe) w_next = S_TURN;
                        else if (host_oe) w_next = S_CONFLICT;
            // OEs raised during turnaround stay pending until the count expires
            S_TURN:     if (r_ta_cnt == 8'd0) w_next = f_grant(host_oe, dev_oe);
            S_CONFLICT: if (!host_oe || !dev_oe) w_next = S_TURN;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_owner = 2'b00;
        case (w_next)
            S_HOST:     w_owner = 2'b01;
            S_DEV:      w_owner = 2'b10;
            S_CONFLICT: w_owner = 2'b11;
            default:    w_owner = 2'b00;
        endcase
    end

    assign w_entry = (w_next == S_CONFLICT) && (r_state != S_CONFLICT);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_ta_cnt   <= 8'd0;
            r_owner    <= 2'b00;
            r_conflict <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_owner    <= w_owner;
            r_conflict <= w_entry;
            // Loaded with TA-1 so that TURN lasts exactly TA_CYCLES cycles
            if (w_next == S_TURN && r_state != S_TURN)
                r_ta_cnt <= TA_LOAD;
            else if (r_state == S_TURN && r_ta_cnt != 8'd0)
                r_ta_cnt <= r_ta_cnt - 8'd1;
            if (w_entry)
                r_cnt <= clr_cnt ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
            else if (clr_cnt)
                r_cnt <= 8'd0;
        end
    end

    always_comb begin
        w_line = LINE_J;
        case (r_state)
            S_HOST:     w_line = {2'b01, host_dp_o, host_dm_o};
            S_DEV:      w_line = {dev_dp_o, dev_dm_o, 2'b01};
            S_CONFLICT: w_line = {dev_dp_o, dev_dm_o, host_dp_o, host_dm_o};
            default:    w_line = LINE_J;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe <= {PROP_DELAY{LINE_J}};
        end else begin
            r_pipe[0] <= w_line;
            for (int i = 1; i < PROP_DELAY; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {host_dp_i, host_dm_i, dev_dp_i, dev_dm_i} = r_pipe[PROP_DELAY-1];
    assign owner        = r_owner;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

`ifdef USB_BUS_SE0_DETECT_EN
    logic [15:0] r_se0_cnt;
    logic [15:0] w_se0_inc;
    logic        r_bus_reset;

    assign w_se0_inc = (r_se0_cnt == 16'hFFFF) ? r_se0_cnt : r_se0_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_se0_cnt   <= 16'd0;
            r_bus_reset <= 1'b0;
        end else if (r_state == S_HOST && !host_dp_o && !host_dm_o) begin
            r_se0_cnt   <= w_se0_inc;
            r_bus_reset <= (w_se0_inc >= 16'(RESET_CYCLES));
        end else begin
            r_se0_cnt   <= 16'd0;
            r_bus_reset <= 1'b0;
        end
    end

    assign bus_reset = r_bus_reset;
`else
    assign bus_reset = 1'b0;
`endif

endmodule
